fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter PC_RESET, default 8'h00, first instruction address after reset.
REQ-002 Parameter DEPTH, default 2, prefetch buffer entries; only 2 supported.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 mem_rd  output  1  instruction-memory read request.
REQ-006 mem_addr  output  8  read address, valid while mem_rd=1.
REQ-007 mem_ready  input  1  memory accepts request and returns mem_rdata this cycle.
REQ-008 mem_rdata  input  8  instruction byte, sampled when mem_rd&&mem_ready.
REQ-009 instruction  output  8  instruction byte presented to the decoder.
REQ-010 instr_valid  output  1  instruction holds an unconsumed byte.
REQ-011 instr_ack  input  1  control consumes instruction this cycle.
REQ-012 pc  output  8  address of the byte currently on instruction.
REQ-013 jump_en  input  1  one-cycle redirect (JMP/CALL/RET taken).
REQ-014 jump_target  input  8  redirect address, sampled when jump_en=1.
REQ-015 halt  input  1  HLT decoded; stop fetching.
REQ-016 halted  output  1  unit is in HALTED state.

Function
REQ-017 FSM states SHALL be REQ, DISCARD, HALTED.
REQ-018 In REQ, mem_rd SHALL be 1 when the buffer is not full, with mem_addr=fetch_pc.
REQ-019 mem_rd and mem_addr SHALL stay stable until mem_ready=1; a request is never withdrawn except by reset.
REQ-020 On mem_rd&&mem_ready, mem_rdata SHALL be written to the buffer tail and fetch_pc incremented modulo 256 (8'hFF wraps to 8'h00).
REQ-021 instr_valid SHALL be 1 exactly when the buffer is non-empty; instruction and pc SHALL come from the buffer head.
REQ-022 Latency SHALL be one cycle: a byte accepted at edge N is visible on instruction after edge N.
REQ-023 instr_valid&&instr_ack SHALL pop the head. A write and a pop in the same cycle SHALL be allowed when the buffer is full.
REQ-024 instr_ack with instr_valid=0 SHALL be ignored.
REQ-025 On jump_en, the buffer SHALL be flushed, fetch_pc SHALL load jump_target, and the next issued pc SHALL equal jump_target.
REQ-026 jump_en SHALL override instr_ack and any buffer write in the same cycle.
REQ-027 If jump_en occurs while a request is pending (mem_rd=1, mem_ready=0), the state SHALL go to DISCARD; the pending response is dropped on mem_ready; the state then returns to REQ at jump_target.
REQ-028 If jump_en coincides with mem_ready, that byte SHALL be dropped; the state SHALL stay REQ with fetch_pc=jump_target.
REQ-029 When halt=1, no new request SHALL start. A pending request SHALL complete and be discarded. The buffer SHALL be flushed, then the state enters HALTED.
REQ-030 In HALTED: mem_rd=0, instr_valid=0, halted=1. jump_en and instr_ack SHALL be ignored. The only exit SHALL be reset.
REQ-031 halt and jump_en in the same cycle: halt SHALL win.

Reset
REQ-032 rst_n=0 SHALL immediately force: state=REQ, buffer empty, fetch_pc=PC_RESET, pc=PC_RESET, instruction=8'h00, instr_valid=0, mem_rd=0, halted=0.
REQ-033 Reset mid-request SHALL abandon the transaction; no late mem_ready is consumed.
REQ-034 mem_rd SHALL first assert in the cycle after rst_n deasserts, at PC_RESET.

Structure
REQ-035 FSM state encodings, PC width (8) and PC_RESET default SHALL live in the shared symbols.vh constant file.
REQ-036 The prefetch buffer SHALL be a sub-module fetch_fifo with push, pop, flush, full, empty, head data and head address.
REQ-037 instruction SHALL connect directly to the decoder instruction input.

Verification
REQ-038 Reset release, mem_ready=1, bytes 8'h40,8'h41,8'h42 at 00..02, ack each cycle -> mem_addr 00,01,02; instruction 40,41,42 with pc 00,01,02, one cycle after each accept.
REQ-039 instr_ack=0 for 4 cycles -> exactly 2 bytes buffered; mem_rd held with mem_addr=02, stable; first ack -> pc 00, then 01.
REQ-040 jump_en, jump_target=8'hA0, while a request to 03 is pending with mem_ready=0 for 3 cycles -> byte for 03 dropped; next mem_addr=A0; next issued pc=A0.
REQ-041 fetch_pc=8'hFF, accept -> next mem_addr=8'h00; issued pcs FF then 00.
REQ-042 halt with a request pending -> pending completes and is discarded; halted=1; mem_rd=0 and instr_valid=0 for 10 cycles despite jump_en; rst_n pulse -> fetch restarts at PC_RESET.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared widths, reset address, FSM encoding and buffer entry type
package fetch_unit_pkg;
  localparam int PC_W = 8;
  localparam logic [PC_W-1:0] PC_RESET_DEF = 8'h00;
  typedef enum logic [1:0] {
    ST_REQ     = 2'd0,
    ST_DISCARD = 2'd1,
    ST_HALTED  = 2'd2
  } state_t;
  typedef struct packed {
    logic [PC_W-1:0] addr;
    logic [7:0]      data;
  } entry_t;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: memory-side and decoder/control-side signals of the fetch unit
interface fetch_unit_if;
  import fetch_unit_pkg::*;
  logic            mem_rd;
  logic [PC_W-1:0] mem_addr;
  logic            mem_ready;
  logic [7:0]      mem_rdata;
  logic [7:0]      instruction;
  logic            instr_valid;
  logic            instr_ack;
  logic [PC_W-1:0] pc;
  logic            jump_en;
  logic [PC_W-1:0] jump_target;
  logic            halt;
  logic            halted;
  modport master (
    output mem_rd, mem_addr, instruction, instr_valid, pc, halted,
    input  mem_ready, mem_rdata, instr_ack, jump_en, jump_target, halt
  );
  modport slave (
    input  mem_rd, mem_addr, instruction, instr_valid, pc, halted,
    output mem_ready, mem_rdata, instr_ack, jump_en, jump_target, halt
  );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: two-entry prefetch buffer of {address, byte} with flush; head is always readable
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int              DEPTH      = 2,
  parameter logic [PC_W-1:0] RESET_ADDR = PC_RESET_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic            flush,
  input  entry_t          wr_entry,
  output logic            full,
  output logic            empty,
  output logic [7:0]      head_data,
  output logic [PC_W-1:0] head_addr
);
  localparam int CW = $clog2(DEPTH + 1);
  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic            rd_q, rd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            do_pop, do_push, wr_idx;
  // occupancy, pointer and storage update; a push into a full buffer is legal only alongside a pop
  always_comb begin
    empty = cnt_q == '0;
    full = cnt_q == CW'(DEPTH);
    do_pop = pop && !empty;
    do_push = push && (!full || do_pop);
    wr_idx = rd_q ^ cnt_q[0];
    mem_d = mem_q;
    if (do_push) mem_d[wr_idx] = wr_entry;
    rd_d = flush ? 1'b0 : rd_q ^ do_pop;
    cnt_d = flush ? '0 : cnt_q + CW'(do_push) - CW'(do_pop);
    head_data = mem_q[rd_q].data;
    head_addr = mem_q[rd_q].addr;
  end
  // storage and pointer registers; reset leaves the head showing byte 00 at RESET_ADDR
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= {RESET_ADDR, 8'h00};
      rd_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction prefetcher with jump redirect, in-flight response discard and halt
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [PC_W-1:0] PC_RESET = PC_RESET_DEF,
  parameter int              DEPTH    = 2
) (
  input logic          clk,
  input logic          rst_n,
  fetch_unit_if.master bus
);
  state_t          state_q, state_d;
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d, disc_addr_q, disc_addr_d;
  logic            halt_q, halt_d, run_q, run_d;
  logic            mem_rd, pending, active, halt_go, jump_go, flush, push, pop, full, empty;
  fetch_fifo #(.DEPTH(DEPTH), .RESET_ADDR(PC_RESET)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .flush(flush),
    .wr_entry({fetch_pc_q, bus.mem_rdata}), .full(full), .empty(empty),
    .head_data(bus.instruction), .head_addr(bus.pc)
  );
  // request qualifiers: a request only issues into free space, so an outstanding one never meets a full buffer
  always_comb begin
    mem_rd = run_q && (state_q == ST_DISCARD || (state_q == ST_REQ && !full));
    pending = mem_rd && !bus.mem_ready;
    active = state_q != ST_HALTED;
    halt_go = active && bus.halt;
    jump_go = active && bus.jump_en && !bus.halt && !halt_q;
    flush = halt_go || jump_go;
    push = state_q == ST_REQ && mem_rd && bus.mem_ready && !flush;
    pop = active && bus.instr_ack && !flush;
  end
  // next state: an outstanding request at redirect/halt must drain through DISCARD
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_REQ:     state_d = flush && pending ? ST_DISCARD : halt_go ? ST_HALTED : ST_REQ;
      ST_DISCARD: state_d = !bus.mem_ready ? ST_DISCARD : (halt_q || halt_go) ? ST_HALTED : ST_REQ;
      default:    state_d = ST_HALTED;
    endcase
  end
  // fetch address bookkeeping; the dropped request keeps its own address while fetch_pc moves to the target
  always_comb begin
    run_d = 1'b1;
    halt_d = halt_q || halt_go;
    disc_addr_d = state_q == ST_REQ && flush && pending ? fetch_pc_q : disc_addr_q;
    fetch_pc_d = jump_go ? bus.jump_target : push ? fetch_pc_q + PC_W'(1) : fetch_pc_q;
  end
  // outputs toward memory and control
  always_comb begin
    bus.mem_rd = mem_rd;
    bus.mem_addr = state_q == ST_DISCARD ? disc_addr_q : fetch_pc_q;
    bus.instr_valid = !empty;
    bus.halted = state_q == ST_HALTED;
  end
  // state register; run_q keeps mem_rd low until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_REQ;
      fetch_pc_q <= PC_RESET;
      disc_addr_q <= PC_RESET;
      halt_q <= 1'b0;
      run_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fetch_pc_q <= fetch_pc_d;
      disc_addr_q <= disc_addr_d;
      halt_q <= halt_d;
      run_q <= run_d;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus random traffic against a queue-based fetch model
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  fetch_unit_if bus();
  fetch_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
  } ent_t;
  ent_t q[$];
  logic [7:0] fpc, daddr, prev_addr;
  bit disc, hlt, hlatch, run, prev_pend;
  logic obs_rd, obs_valid, obs_halted;
  logic [7:0] obs_addr, obs_instr, obs_pc;
  int n_chk = 0;
  int n_pass = 0;
  // compare one observed value against the bench expectation
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask
  task automatic drive(input bit rdy, input logic [7:0] rdata, input bit ack, input bit jmp, input logic [7:0] tgt, input bit h);
    bus.mem_ready = rdy;
    bus.mem_rdata = rdata;
    bus.instr_ack = ack;
    bus.jump_en = jmp;
    bus.jump_target = tgt;
    bus.halt = h;
  endtask
  task automatic do_reset(input int hold);
    @(negedge clk);
    rst_n = 1'b0;
    drive(0, 8'h00, 0, 0, 8'h00, 0);
    #1;
    check("rst_mem_rd", bus.mem_rd, 0);
    check("rst_valid", bus.instr_valid, 0);
    check("rst_pc", bus.pc, 8'h00);
    check("rst_instruction", bus.instruction, 8'h00);
    check("rst_halted", bus.halted, 0);
    q.delete();
    fpc = 8'h00;
    daddr = 8'h00;
    disc = 0;
    hlt = 0;
    hlatch = 0;
    run = 0;
    prev_pend = 0;
    repeat (hold) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release_mem_rd", bus.mem_rd, 0);
    run = 1;
  endtask
  // one clock: drive inputs, check outputs against the model, then advance the model across the edge
  task automatic cycle(input bit rdy, input logic [7:0] rdata, input bit ack, input bit jmp, input logic [7:0] tgt, input bit h);
    bit e_rd, e_valid, pend, waiting;
    @(negedge clk);
    drive(rdy, rdata, ack, jmp, tgt, h);
    #1;
    obs_rd = bus.mem_rd;
    obs_addr = bus.mem_addr;
    obs_valid = bus.instr_valid;
    obs_instr = bus.instruction;
    obs_pc = bus.pc;
    obs_halted = bus.halted;
    e_rd = run && !hlt && (disc || q.size() < 2);
    e_valid = q.size() > 0;
    check("mem_rd", obs_rd, e_rd);
    if (e_rd) check("mem_addr", obs_addr, disc ? daddr : fpc);
    check("instr_valid", obs_valid, e_valid);
    if (e_valid) begin
      check("instruction", obs_instr, q[0].d);
      check("pc", obs_pc, q[0].a);
    end
    check("halted", obs_halted, hlt);
    if (prev_pend) begin
      check("hold_mem_rd", obs_rd, 1);
      check("hold_mem_addr", obs_addr, prev_addr);
    end
    prev_pend = obs_rd && !rdy;
    prev_addr = obs_addr;
    if (!hlt) begin
      pend = e_rd && !rdy;
      waiting = disc ? !rdy : pend;
      if (h || hlatch) begin
        q.delete();
        if (!disc && pend) daddr = fpc;
        hlatch = 1;
        disc = waiting;
        hlt = !waiting;
      end else if (jmp) begin
        q.delete();
        if (!disc && pend) daddr = fpc;
        fpc = tgt;
        disc = waiting;
      end else if (disc) begin
        disc = !rdy;
      end else begin
        if (ack && q.size() > 0) void'(q.pop_front());
        if (e_rd && rdy) begin
          q.push_back('{fpc, rdata});
          fpc = fpc + 8'd1;
        end
      end
    end
  endtask
  initial begin
    drive(0, 8'h00, 0, 0, 8'h00, 0);
    // streaming with ack every cycle
    do_reset(2);
    for (int i = 0; i < 4; i++) begin
      cycle(1, 8'h40 + 8'(i), 1, 0, 8'h00, 0);
      if (i < 3) check("d_stream_addr", obs_addr, 8'(i));
      if (i > 0) begin
        check("d_stream_instr", obs_instr, 8'h40 + 8'(i - 1));
        check("d_stream_pc", obs_pc, 8'(i - 1));
      end
    end
    // back-pressure fills the buffer with exactly two bytes
    do_reset(2);
    for (int i = 0; i < 4; i++) cycle(1, 8'h50 + 8'(i), 0, 0, 8'h00, 0);
    check("d_full_rd", obs_rd, 0);
    check("d_full_addr", obs_addr, 8'h02);
    check("d_full_pc", obs_pc, 8'h00);
    cycle(0, 8'h00, 1, 0, 8'h00, 0);
    check("d_full_ack0", obs_pc, 8'h00);
    cycle(0, 8'h00, 1, 0, 8'h00, 0);
    check("d_full_ack1", obs_pc, 8'h01);
    cycle(0, 8'h00, 0, 0, 8'h00, 0);
    check("d_full_hold_rd", obs_rd, 1);
    check("d_full_hold_addr", obs_addr, 8'h02);
    // jump while a request is outstanding
    do_reset(2);
    for (int i = 0; i < 3; i++) cycle(1, 8'h40 + 8'(i), 1, 0, 8'h00, 0);
    cycle(0, 8'h00, 1, 0, 8'h00, 0);
    check("d_jmp_pend_addr", obs_addr, 8'h03);
    cycle(0, 8'h00, 0, 1, 8'hA0, 0);
    cycle(0, 8'h00, 0, 0, 8'h00, 0);
    check("d_jmp_disc_addr", obs_addr, 8'h03);
    cycle(1, 8'hEE, 0, 0, 8'h00, 0);
    cycle(1, 8'h77, 0, 0, 8'h00, 0);
    check("d_jmp_new_addr", obs_addr, 8'hA0);
    cycle(0, 8'h00, 0, 0, 8'h00, 0);
    check("d_jmp_pc", obs_pc, 8'hA0);
    check("d_jmp_instr", obs_instr, 8'h77);
    // fetch address wraps from FF to 00
    do_reset(2);
    cycle(1, 8'h11, 0, 1, 8'hFF, 0);
    cycle(1, 8'h11, 1, 0, 8'h00, 0);
    check("d_wrap_addr_ff", obs_addr, 8'hFF);
    cycle(1, 8'h22, 1, 0, 8'h00, 0);
    check("d_wrap_addr_00", obs_addr, 8'h00);
    check("d_wrap_pc_ff", obs_pc, 8'hFF);
    cycle(0, 8'h00, 1, 0, 8'h00, 0);
    check("d_wrap_pc_00", obs_pc, 8'h00);
    check("d_wrap_instr", obs_instr, 8'h22);
    // halt with a request outstanding, then reset restarts fetch
    do_reset(2);
    cycle(1, 8'h40, 0, 0, 8'h00, 0);
    cycle(0, 8'h00, 0, 0, 8'h00, 1);
    cycle(0, 8'h00, 0, 0, 8'h00, 0);
    check("d_halt_drain_rd", obs_rd, 1);
    check("d_halt_drain_addr", obs_addr, 8'h01);
    check("d_halt_drain_valid", obs_valid, 0);
    cycle(1, 8'h99, 0, 0, 8'h00, 0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'($urandom_range(0, 1)), 8'($urandom), 1, 1, 8'($urandom), 0);
      check("d_halted_rd", obs_rd, 0);
      check("d_halted_valid", obs_valid, 0);
      check("d_halted_flag", obs_halted, 1);
    end
    do_reset(2);
    cycle(1, 8'h5A, 0, 0, 8'h00, 0);
    check("d_restart_rd", obs_rd, 1);
    check("d_restart_addr", obs_addr, 8'h00);
    // random traffic episodes, each starting from a reset that may cut a request short
    for (int e = 0; e < 8; e++) begin
      do_reset(int'($urandom_range(1, 3)));
      for (int c = 0; c < int'($urandom_range(150, 500)); c++)
        cycle(1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 2) != 0,
              $urandom_range(0, 15) == 0, 8'($urandom), $urandom_range(0, 299) == 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
